// File: rtl/fifo_host_spi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_host_spi
// Drains measurement words from the syn_fifo result buffer and serves them to
// the host MCU over an SPI-slave link (mode 0, MSB first). Each CS window
// carries one frame: {valid, more, seq[5:0], data[23:0]}. One word is
// prefetched into a hold register; data_ready tells the host a frame waits.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   fifo_data_out  syn_fifo read data, valid the cycle after fifo_rd_en
//   fifo_empty     syn_fifo empty flag
//   fifo_rd_en     one-cycle pop strobe to syn_fifo
//   host_sck       host SPI clock (asynchronous)
//   host_cs_n      host chip select, active low (asynchronous)
//   host_miso      serial data to host
//   data_ready     high while the hold register has an unsent word
//   frames_sent    count of completed valid frames (wraps)
// -----------------------------------------------------------------------------
module fifo_host_spi #(
  parameter int DATA_WIDTH  = 24,
  parameter int HDR_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  host_sck,
  input  logic                  host_cs_n,
  output logic                  host_miso,
  output logic                  data_ready,
  output logic [15:0]           frames_sent
);

  localparam int FRAME_WIDTH = HDR_WIDTH + DATA_WIDTH;
  localparam int SEQ_WIDTH   = HDR_WIDTH - 2;
  localparam int CNT_WIDTH   = $clog2(FRAME_WIDTH + 2);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FRAME_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(FRAME_WIDTH + 1);

  // POP: strobe is on the wire; LATCH: fifo_data_out is valid this cycle.
  typedef enum logic [2:0] {EMPTY, POP, LATCH, HELD, SHIFT} state_t;

  state_t                  state, state_next;
  logic [SYNC_STAGES-1:0]  sck_sync, cs_sync;
  logic                    sck_prev;
  logic                    sck_s, cs_s, sck_fall;

  logic [DATA_WIDTH-1:0]   hold, hold_next;
  logic                    hold_valid, hold_valid_next;
  logic [SEQ_WIDTH-1:0]    seq, seq_next;
  logic [FRAME_WIDTH-1:0]  shifter, shifter_next;
  logic [CNT_WIDTH-1:0]    bit_cnt, bit_cnt_next;
  logic                    frame_valid, frame_valid_next;
  logic                    rd_en_next;
  logic [15:0]             frames_next;

  // Synchronisers; CS idles high so the chain resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], host_sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], host_cs_n};
      sck_prev <= sck_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_fall = sck_prev & ~sck_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      hold        <= '0;
      hold_valid  <= 1'b0;
      seq         <= '0;
      shifter     <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      fifo_rd_en  <= 1'b0;
      frames_sent <= '0;
    end else begin
      state       <= state_next;
      hold        <= hold_next;
      hold_valid  <= hold_valid_next;
      seq         <= seq_next;
      shifter     <= shifter_next;
      bit_cnt     <= bit_cnt_next;
      frame_valid <= frame_valid_next;
      fifo_rd_en  <= rd_en_next;
      frames_sent <= frames_next;
    end
  end

  always_comb begin
    state_next       = state;
    hold_next        = hold;
    hold_valid_next  = hold_valid;
    seq_next         = seq;
    shifter_next     = shifter;
    bit_cnt_next     = bit_cnt;
    frame_valid_next = frame_valid;
    rd_en_next       = 1'b0;
    frames_next      = frames_sent;

    case (state)
      EMPTY: begin
        // CS is checked as a level: a fall seen here (or deferred through
        // POP/LATCH) starts the frame; prefetch only happens with CS high.
        if (!cs_s) begin
          shifter_next     = '0;
          frame_valid_next = 1'b0;
          bit_cnt_next     = '0;
          state_next       = SHIFT;
        end else if (!fifo_empty) begin
          rd_en_next = 1'b1;
          state_next = POP;
        end
      end
      POP: begin
        state_next = LATCH;
      end
      LATCH: begin
        hold_next       = fifo_data_out;
        hold_valid_next = 1'b1;
        state_next      = HELD;
      end
      HELD: begin
        if (!cs_s) begin
          shifter_next     = {1'b1, ~fifo_empty, seq, hold};
          frame_valid_next = 1'b1;
          bit_cnt_next     = '0;
          state_next       = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          shifter_next = '0;
          if (frame_valid && (bit_cnt == CNT_FULL)) begin
            hold_valid_next = 1'b0;
            seq_next        = seq + 1'b1;
            frames_next     = frames_sent + 16'd1;
            state_next      = EMPTY;
          end else begin
            // Short or over-long window: keep the word for a full resend.
            state_next = hold_valid ? HELD : EMPTY;
          end
        end else if (sck_fall) begin
          // Zero fill makes bits beyond the frame read as 0.
          shifter_next = {shifter[FRAME_WIDTH-2:0], 1'b0};
          if (bit_cnt != CNT_MAX) begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  assign host_miso  = shifter[FRAME_WIDTH-1];
  assign data_ready = hold_valid;

endmodule

// File: tb/tb_fifo_host_spi.sv
`timescale 1ns/1ps
module tb_fifo_host_spi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] fifo_data_out = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        host_sck = 1'b0;
  logic        host_cs_n = 1'b1;
  logic        host_miso;
  logic        data_ready;
  logic [15:0] frames_sent;

  int checks = 0;
  int failures = 0;

  fifo_host_spi dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_data_out(fifo_data_out),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .host_sck     (host_sck),
    .host_cs_n    (host_cs_n),
    .host_miso    (host_miso),
    .data_ready   (data_ready),
    .frames_sent  (frames_sent)
  );

  always #5 clk = ~clk;

  // ---------------- syn_fifo stand-in ----------------
  logic [23:0] fifo_mem [256];
  logic [7:0]  wr_ptr = '0;
  logic [7:0]  rd_ptr = '0;
  int          rd_pulses = 0;
  int          underflow = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_pulses <= rd_pulses + 1;
      if (fifo_empty) underflow <= underflow + 1;
      else begin
        fifo_data_out <= fifo_mem[rd_ptr];
        rd_ptr        <= rd_ptr + 8'd1;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  logic [23:0] mq[$];
  logic [23:0] m_hold = '0;
  logic        m_hold_valid = 1'b0;
  int          m_seq = 0;
  int          m_frames = 0;
  int          m_pops = 0;

  task automatic model_refill();
    if (!m_hold_valid && mq.size() > 0) begin
      m_hold       = mq.pop_front();
      m_hold_valid = 1'b1;
      m_pops++;
    end
  endtask

  task automatic model_xfer(input int nsck, output logic [31:0] f);
    if (m_hold_valid) begin
      f = {1'b1, (mq.size() != 0), 6'(m_seq), m_hold};
      if (nsck == 32) begin
        m_hold_valid = 1'b0;
        m_seq        = (m_seq + 1) % 64;
        m_frames     = (m_frames + 1) % 65536;
      end
    end else begin
      f = '0;
    end
    model_refill();
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [23:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
    mq.push_back(w);
    model_refill();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    host_cs_n = 1'b1;
    host_sck = 1'b0;
    wait_clk(2);
    check("rst_miso", host_miso, 0);
    check("rst_ready", data_ready, 0);
    check("rst_frames", frames_sent, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    rst = 1'b0;
    m_hold_valid = 1'b0;
    m_seq = 0;
    m_frames = 0;
    model_refill();
    wait_clk(4);
  endtask

  // One CS window with nsck SCK pulses; host samples MISO before each rise.
  task automatic spi_xfer(input int nsck, output logic [63:0] rx);
    check("miso_idle", host_miso, 0);
    host_cs_n = 1'b0;
    wait_clk(6);
    rx = '0;
    for (int i = 0; i < nsck; i++) begin
      rx = {rx[62:0], host_miso};
      host_sck = 1'b1;
      wait_clk(5);
      host_sck = 1'b0;
      wait_clk(5);
    end
    wait_clk(1);
    host_cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic compare_rx(input string name, input int nsck, input logic [63:0] rx,
                            input logic [31:0] frame);
    logic [63:0] e;
    e = '0;
    for (int i = 0; i < nsck; i++) begin
      e = {e[62:0], (i < 32) ? frame[31-i] : 1'b0};
    end
    check(name, rx, e);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_first;
    int          npush;
    logic [23:0] w0;
    logic [23:0] w1;
    int          nsck;
    logic [31:0] exp_frame;
    logic [15:0] exp_frames;
    logic        exp_ready;
    int          exp_pops;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rx;
    logic [31:0] mf;
    int base;
    int nsck;

    tbl[0] = '{1'b0, 0, 24'h000000, 24'h000000, 32, 32'h00000000, 16'd0, 1'b0, 0};
    tbl[1] = '{1'b0, 1, 24'hABCDEF, 24'h000000, 32, 32'h80ABCDEF, 16'd1, 1'b0, 1};
    tbl[2] = '{1'b1, 2, 24'h000001, 24'h000002, 32, 32'hC0000001, 16'd1, 1'b1, 2};
    tbl[3] = '{1'b0, 0, 24'h000000, 24'h000000, 32, 32'h81000002, 16'd2, 1'b0, 0};
    tbl[4] = '{1'b0, 1, 24'h123456, 24'h000000, 10, 32'h82123456, 16'd2, 1'b1, 1};
    tbl[5] = '{1'b0, 0, 24'h000000, 24'h000000, 32, 32'h82123456, 16'd3, 1'b0, 0};
    tbl[6] = '{1'b0, 1, 24'h00BEEF, 24'h000000, 40, 32'h8300BEEF, 16'd3, 1'b1, 1};
    tbl[7] = '{1'b0, 0, 24'h000000, 24'h000000, 32, 32'h8300BEEF, 16'd4, 1'b0, 0};

    do_reset();

    for (int k = 0; k < 8; k++) begin
      if (tbl[k].rst_first) do_reset();
      base = rd_pulses;
      if (tbl[k].npush > 0) push_word(tbl[k].w0);
      if (tbl[k].npush > 1) push_word(tbl[k].w1);
      wait_clk(10);
      spi_xfer(tbl[k].nsck, rx);
      model_xfer(tbl[k].nsck, mf);
      compare_rx($sformatf("vec%0d_frame", k), tbl[k].nsck, rx, tbl[k].exp_frame);
      check($sformatf("vec%0d_frames_sent", k), frames_sent, tbl[k].exp_frames);
      check($sformatf("vec%0d_data_ready", k), data_ready, tbl[k].exp_ready);
      check($sformatf("vec%0d_pops", k), rd_pulses - base, tbl[k].exp_pops);
    end

    // Sequence field wrap over 65 back-to-back frames.
    do_reset();
    for (int i = 0; i < 65; i++) push_word(24'($urandom));
    wait_clk(10);
    for (int f = 0; f < 65; f++) begin
      spi_xfer(32, rx);
      model_xfer(32, mf);
      compare_rx($sformatf("wrap%0d_frame", f), 32, rx, mf);
      if (f == 63) check("wrap_seq63", rx[29:24], 63);
      if (f == 64) check("wrap_seq0", rx[29:24], 0);
    end
    check("wrap_frames_sent", frames_sent, 65);

    // Reset in the middle of a frame.
    do_reset();
    push_word(24'h000777);
    wait_clk(10);
    spi_xfer(32, rx);
    model_xfer(32, mf);
    compare_rx("prerst_frame", 32, rx, 32'h80000777);
    check("prerst_frames_sent", frames_sent, 1);
    push_word(24'hFFFFFF);
    wait_clk(10);
    host_cs_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 12; i++) begin
      host_sck = 1'b1;
      wait_clk(5);
      host_sck = 1'b0;
      wait_clk(5);
    end
    host_sck = 1'b1;
    wait_clk(2);
    check("midrst_miso_before", host_miso, 1);
    rst = 1'b1;
    #1;
    check("midrst_miso", host_miso, 0);
    check("midrst_ready", data_ready, 0);
    check("midrst_frames", frames_sent, 0);
    check("midrst_rd_en", fifo_rd_en, 0);
    wait_clk(2);
    host_sck = 1'b0;
    host_cs_n = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    m_hold_valid = 1'b0;
    m_seq = 0;
    m_frames = 0;
    wait_clk(10);
    check("postrst_ready", data_ready, 0);
    spi_xfer(32, rx);
    model_xfer(32, mf);
    compare_rx("postrst_null_frame", 32, rx, 32'h00000000);
    check("postrst_frames", frames_sent, 0);

    // Randomised traffic against the model.
    for (int t = 0; t < 30; t++) begin
      int np;
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) push_word(24'($urandom));
      case ($urandom_range(0, 3))
        0, 1:    nsck = 32;
        2:       nsck = $urandom_range(1, 31);
        default: nsck = $urandom_range(33, 36);
      endcase
      wait_clk(10);
      check($sformatf("rnd%0d_ready", t), data_ready, m_hold_valid);
      spi_xfer(nsck, rx);
      model_xfer(nsck, mf);
      compare_rx($sformatf("rnd%0d_frame_n%0d", t, nsck), nsck, rx, mf);
      check($sformatf("rnd%0d_frames_sent", t), frames_sent, 16'(m_frames));
    end

    check("total_pops", rd_pulses, m_pops);
    check("no_underflow", underflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
